rgb_pwm_ctrl: RTL
=================

# rgb_pwm_ctrl

Parametrised multi-channel PWM LED controller that replaces raw GPIO bit-banging of the RGB driver's PWM inputs. A register write/read port on the SoC bus side configures a global prescaler and, per channel, a duty value and a mode (static, breathe, blink, off). It drives glitch-free PWM waveforms into the RGB LED driver's PWM inputs. Duty changes are double-buffered and take effect only at PWM period boundaries.

## Interface
Parameters:
- CHANNELS, 3: number of PWM outputs (1..15).
- PWM_WIDTH, 8: duty and counter width W. Period is 2^W-1 ticks.
- PRESCALE_WIDTH, 8: prescaler reload width.
- BLINK_PERIODS, 32: PWM periods per blink half-phase (≥1).

Ports:
- HCLK  in  1  sole clock.
- HRESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  register write strobe, one write per cycle.
- addr  in  4  register address, shared by read and write.
- wr_data  in  32  write data.
- rd_data  out  32  combinational read of the addressed pending register. Reads 0 for unmapped addresses.
- pwm_out  out  CHANNELS  registered PWM outputs; bit n goes to RGB driver PWM input n.
- period_tick  out  1  registered one-cycle pulse at each PWM period end.

## Operation
- Register map:
  - addr 0 = CTRL: bit0 enable, bits[8+PRESCALE_WIDTH-1:8] prescale.
  - addr 1+n = CHn: bits[W-1:0] duty/peak, bits[W+1:W] mode (00 static, 01 breathe, 10 blink, 11 off).
  - Unused bits read 0. Writes to unmapped addresses are ignored.
- Prescaler counts 0..prescale and raises an internal tick when count == prescale, then reloads 0. prescale=0 gives a tick every cycle.
- Period counter cnt runs 0..2^W-2 and advances on tick. A period ends on a tick with cnt == 2^W-2; cnt then wraps to 0.
- Each channel has a shadow register holding {mode, duty}, loaded from its pending CHn register at every period end.
- Effective duty e per channel:
  - static: e = duty.
  - off: e = 0.
  - breathe: e = level_n.
  - blink: e = duty during the on-phase, 0 during the off-phase.
- pwm_out[n] is registered from (cnt < e). e=0 gives constant low; e=2^W-1 gives constant high.
- Breathe, evaluated at each period end using shadow peak P:
  - Direction up and level < P: level+1.
  - Direction up and level ≥ P: flip to down, then level-1 if level > 0.
  - Direction down and level > 0: level-1.
  - Direction down and level = 0: flip to up, then level+1 if P > 0.
  - P=0 holds level at 0. If P is lowered below the current level while up, the level ramps down next period.
  - Level and direction reset to 0/up whenever the shadow mode is not breathe.
- Blink: a single shared period counter, so all channels stay in phase. Phase toggles after BLINK_PERIODS period ends. The first phase after enable is on.
- Disabled (enable=0):
  - Prescaler, cnt, breathe levels and blink state held at reset values.
  - pwm_out = 0 and period_tick = 0.
  - Shadows load continuously from pending registers.
- Enable 0→1: counting starts from cnt=0 on the next cycle.

## Timing
- Reset values:
  - All pending and shadow registers 0; prescale 0; enable 0.
  - cnt 0; breathe level 0 with direction up; blink phase on.
  - pwm_out 0; period_tick 0.
- Register write lands on the HCLK edge where wr_en=1. rd_data shows the new value from the next cycle.
- A write to CHn reaches pwm_out at the first period boundary after the write, never mid-period.
- Write on the same cycle as a period end: the shadow loads the pre-write value, and the new value applies one period later.
- A CTRL prescale write takes effect at the next prescaler reload.
- Clearing enable forces pwm_out = 0 one cycle later.
- pwm_out[n] reflects cnt one cycle after cnt changes, a fixed 1-cycle latency.
- period_tick asserts in the cycle after the period-end tick, coincident with the first pwm_out of the new period.
- Asserting HRESET forces all outputs to 0 immediately, asynchronously, including mid-period. Operation resumes from reset state on the first edge after deassertion.

## Test plan
- Reset check: HRESET pulse mid-operation → pwm_out=0 and period_tick=0 immediately; every rd_data address reads 0.
- Static duty, W=8, prescale=0, CH0 duty=64, enable → period_tick every 255 cycles; pwm_out[0] high for exactly 64 cycles per period; CH1/CH2 low.
- Extremes: CH0=0, CH1=255, CH2=128, prescale=3 → ch0 constant 0, ch1 constant 1, ch2 high for 512 of every 1020 cycles.
- Glitch-free update: CH0 duty 200→10 written at cnt=50 → current period completes with 200 high ticks; next period has 10. Also a write coincident with period end → change applies one period later.
- Breathe: CH0 mode=01, peak=4 → per-period high counts 0,1,2,3,4,3,2,1,0,1. Peak=0 → always 0.
- Blink with BLINK_PERIODS=2, CH2 duty=100 → high counts 100,100,0,0,100,100. Clearing enable mid-run → pwm_out=0 next cycle; re-enable restarts on-phase at cnt=0.

Source files
------------

// File: rtl/rgb_pwm_ctrl.sv
// Multi-channel PWM LED controller: register port sets prescaler plus per-channel duty/mode (static, breathe, blink, off).
// Latency: writes readable next cycle; duty/mode changes reach pwm_out at the next PWM period boundary only.
// Backpressure: none; one register write per cycle is always accepted, outputs are free-running.
module rgb_pwm_ctrl #(
  parameter int CHANNELS       = 3,
  parameter int PWM_WIDTH      = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int BLINK_PERIODS  = 32
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic                wr_en,
  input  logic [3:0]          addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick
);

  localparam int W   = PWM_WIDTH;
  localparam int CW  = PWM_WIDTH + 2;
  localparam int PW  = PRESCALE_WIDTH;
  localparam int BCW = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [W-1:0]   CNT_LAST   = {{(W-1){1'b1}}, 1'b0};
  localparam logic [BCW-1:0] BLINK_LAST = BCW'(BLINK_PERIODS - 1);

  typedef enum logic [1:0] {
    MODE_STATIC  = 2'b00,
    MODE_BREATHE = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_OFF     = 2'b11
  } mode_e;

  logic                         enable;
  logic [PW-1:0]                prescale;
  logic [CHANNELS-1:0][CW-1:0]  pend, shadow, shadow_nxt;
  logic [PW-1:0]                pre_cnt, pre_cnt_nxt, pre_lim, pre_lim_nxt, pre_limit;
  logic [W-1:0]                 cnt, cnt_nxt;
  logic [CHANNELS-1:0][W-1:0]   level, level_nxt, duty_eff;
  logic [CHANNELS-1:0]          dir_down, dir_down_nxt, pwm_nxt;
  logic                         blink_on, blink_on_nxt;
  logic [BCW-1:0]               blink_cnt, blink_cnt_nxt;
  logic                         en_nxt, tick, period_end;
  logic                         unused_wr_data;

  // Upper write-data bits beyond the mapped fields carry no meaning.
  assign unused_wr_data = ^wr_data;

  // Bus-side pending registers: CTRL and one CHn word per channel.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      enable   <= 1'b0;
      prescale <= '0;
      pend     <= '0;
    end else if (wr_en) begin
      if (addr == 4'd0) begin
        enable   <= wr_data[0];
        prescale <= wr_data[8 +: PW];
      end
      for (int n = 0; n < CHANNELS; n++) begin
        if (addr == 4'(n + 1)) pend[n] <= wr_data[CW-1:0];
      end
    end
  end

  // Combinational read of the addressed pending register; unmapped reads 0.
  always_comb begin
    rd_data = '0;
    if (addr == 4'd0) begin
      rd_data[0]       = enable;
      rd_data[8 +: PW] = prescale;
    end
    for (int n = 0; n < CHANNELS; n++) begin
      if (addr == 4'(n + 1)) rd_data[CW-1:0] = pend[n];
    end
  end

  // Timebase: prescaler, period counter and shared blink phase.
  // A new prescale is sampled only when the prescaler sits at 0, so it
  // applies from the next reload rather than truncating a count in flight.
  always_comb begin
    en_nxt        = (wr_en && addr == 4'd0) ? wr_data[0] : enable;
    pre_limit     = (pre_cnt == '0) ? prescale : pre_lim;
    tick          = enable && (pre_cnt == pre_limit);
    period_end    = tick && (cnt == CNT_LAST);
    pre_lim_nxt   = pre_limit;
    pre_cnt_nxt   = (!enable || tick) ? '0 : pre_cnt + 1'b1;
    cnt_nxt       = cnt;
    blink_on_nxt  = blink_on;
    blink_cnt_nxt = blink_cnt;
    if (!enable) begin
      cnt_nxt       = '0;
      blink_on_nxt  = 1'b1;
      blink_cnt_nxt = '0;
    end else begin
      if (tick) cnt_nxt = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      if (period_end) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_on_nxt  = ~blink_on;
          blink_cnt_nxt = '0;
        end else begin
          blink_cnt_nxt = blink_cnt + 1'b1;
        end
      end
    end
  end

  // Per-channel shadow load, breathe ramp and effective duty. Everything is
  // computed from next-state values so pwm_out and period_tick line up with
  // the first counter value of a new period.
  always_comb begin
    shadow_nxt   = shadow;
    level_nxt    = level;
    dir_down_nxt = dir_down;
    duty_eff     = '0;
    pwm_nxt      = '0;
    for (int n = 0; n < CHANNELS; n++) begin
      if (!enable || period_end) shadow_nxt[n] = pend[n];
      // The ramp steps with the peak of the period that is ending.
      if (!enable || mode_e'(shadow[n][CW-1:W]) != MODE_BREATHE) begin
        level_nxt[n]    = '0;
        dir_down_nxt[n] = 1'b0;
      end else if (period_end) begin
        if (!dir_down[n]) begin
          if (level[n] < shadow[n][W-1:0]) begin
            level_nxt[n] = level[n] + 1'b1;
          end else begin
            dir_down_nxt[n] = 1'b1;
            if (level[n] != '0) level_nxt[n] = level[n] - 1'b1;
          end
        end else begin
          if (level[n] != '0) begin
            level_nxt[n] = level[n] - 1'b1;
          end else begin
            dir_down_nxt[n] = 1'b0;
            if (shadow[n][W-1:0] != '0) level_nxt[n] = level[n] + 1'b1;
          end
        end
      end
      case (mode_e'(shadow_nxt[n][CW-1:W]))
        MODE_STATIC:  duty_eff[n] = shadow_nxt[n][W-1:0];
        MODE_BREATHE: duty_eff[n] = level_nxt[n];
        MODE_BLINK:   duty_eff[n] = blink_on_nxt ? shadow_nxt[n][W-1:0] : '0;
        default:      duty_eff[n] = '0;
      endcase
      pwm_nxt[n] = en_nxt && (cnt_nxt < duty_eff[n]);
    end
  end

  // State and output registers; reset clears outputs asynchronously.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      pre_cnt     <= '0;
      pre_lim     <= '0;
      cnt         <= '0;
      shadow      <= '0;
      level       <= '0;
      dir_down    <= '0;
      blink_on    <= 1'b1;
      blink_cnt   <= '0;
      pwm_out     <= '0;
      period_tick <= 1'b0;
    end else begin
      pre_cnt     <= pre_cnt_nxt;
      pre_lim     <= pre_lim_nxt;
      cnt         <= cnt_nxt;
      shadow      <= shadow_nxt;
      level       <= level_nxt;
      dir_down    <= dir_down_nxt;
      blink_on    <= blink_on_nxt;
      blink_cnt   <= blink_cnt_nxt;
      pwm_out     <= pwm_nxt;
      period_tick <= period_end && en_nxt;
    end
  end

endmodule
